irrigation_scheduler: RTL and testbench

Round-robin watering scheduler that shares one valve-timing counter among several irrigation zones. Zones raise level requests. The block grants one zone at a time, opens its valve for a fixed number of time-base ticks, then holds a settle interval with all valves closed before serving the next zone. It sits between the per-zone soil-moisture logic and the valve drivers, and exposes its 4-bit tick count for the display path.

---
 rtl/irrigation_scheduler.sv | 170 +++++++++++++++++
 tb/tb_irrigation_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/irrigation_scheduler.sv
// Round-robin irrigation scheduler: one shared valve-timing counter serves ZONES zones in turn.
// Latency: one cycle from a request seen in IDLE to the valve opening; every output is registered.
// Backpressure: none. Requests are level-sensitive and only sampled in IDLE; stop aborts at once.
//
// Ports:
//   clk    - single clock, every register updates on the rising edge
//   rst_n  - synchronous active-low reset
//   tick   - one-cycle time-base strobe (ignored in IDLE and on the grant cycle)
//   req    - per-zone level request (1 = soil dry)
//   stop   - global abort (reservoir empty / rain), level
//   valve  - one-hot or zero valve enables
//   zone   - index of the zone currently or most recently granted
//   count  - tick count within OPEN or SETTLE, 0 in IDLE
//   busy   - high whenever the scheduler is not IDLE
//   done   - one-cycle pulse when a watering finishes (normally or early)

module irrigation_scheduler #(
    parameter int ZONES        = 4,
    parameter int WATER_TICKS  = 10,
    parameter int SETTLE_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [ZONES-1:0] req,
    input  logic             stop,
    output logic [ZONES-1:0] valve,
    output logic [1:0]       zone,
    output logic [3:0]       count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [3:0] WATER_LAST  = 4'(WATER_TICKS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_TICKS - 1);
    localparam logic [1:0] LAST_RST    = 2'(ZONES - 1);
    localparam logic [2:0] ZONES_W     = 3'(ZONES);

    state_t           state_q, state_d;
    logic [1:0]       last_q,  last_d;
    logic [1:0]       zone_q,  zone_d;
    logic [3:0]       count_q, count_d;
    logic [ZONES-1:0] valve_q, valve_d;
    logic             done_q,  done_d;

    // Requests widened to the full 2-bit index space so any zone index can
    // select a bit without width juggling when ZONES < 4.
    logic [3:0] req_ext;
    logic [1:0] grant;
    logic       grant_vld;
    logic [2:0] cand;
    logic [3:0] grant_oh;

    always_comb begin
        req_ext            = '0;
        req_ext[ZONES-1:0] = req;
    end

    // Round-robin search starting at last+1. Candidates are walked from the
    // farthest offset down to the nearest so the nearest requesting zone is
    // the last assignment and therefore wins. last < ZONES and the offset is
    // at most ZONES, so a single conditional subtract gives the modulo.
    always_comb begin
        grant     = '0;
        grant_vld = |req;
        cand      = '0;
        for (int i = ZONES; i >= 1; i--) begin
            cand = {1'b0, last_q} + 3'(i);
            if (cand >= ZONES_W) begin
                cand = cand - ZONES_W;
            end
            if (req_ext[cand[1:0]]) begin
                grant = cand[1:0];
            end
        end
    end

    assign grant_oh = 4'b0001 << grant;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        zone_d  = zone_q;
        count_d = count_q;
        valve_d = valve_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!stop && grant_vld) begin
                    state_d = ST_OPEN;
                    zone_d  = grant;
                    last_d  = grant;
                    valve_d = grant_oh[ZONES-1:0];
                    count_d = '0;
                end
            end

            ST_OPEN: begin
                if (stop) begin
                    // Abort: last keeps the aborted zone so it loses its turn.
                    state_d = ST_IDLE;
                    valve_d = '0;
                    count_d = '0;
                end else if (!req_ext[zone_q] || (tick && count_q == WATER_LAST)) begin
                    // Early satisfaction and the final tick share one exit,
                    // so a coincident drop and final tick yield a single done.
                    state_d = ST_SETTLE;
                    valve_d = '0;
                    count_d = '0;
                    done_d  = 1'b1;
                end else if (tick) begin
                    count_d = count_q + 4'd1;
                end
            end

            ST_SETTLE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    valve_d = '0;
                    count_d = '0;
                end else if (tick) begin
                    if (count_q == SETTLE_LAST) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                valve_d = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_RST;
            zone_q  <= '0;
            count_q <= '0;
            valve_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            zone_q  <= zone_d;
            count_q <= count_d;
            valve_q <= valve_d;
            done_q  <= done_d;
        end
    end

    assign valve = valve_q;
    assign zone  = zone_q;
    assign count = count_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Bench for irrigation_scheduler: a default-timing instance and a 1-tick/1-tick instance share stimulus.
// Latency: outputs compared 1 time unit after every rising edge against a per-zone-turn reference.
// Backpressure: not applicable; inputs change on the falling edge only.

module tb_irrigation_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       stop;
    logic [3:0] req;

    logic [3:0] valve_a, valve_b;
    logic [1:0] zone_a,  zone_b;
    logic [3:0] count_a, count_b;
    logic       busy_a,  busy_b;
    logic       done_a,  done_b;

    always #5 clk = ~clk;

    irrigation_scheduler #(.ZONES(4), .WATER_TICKS(10), .SETTLE_TICKS(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .stop(stop),
        .valve(valve_a), .zone(zone_a), .count(count_a), .busy(busy_a), .done(done_a)
    );

    irrigation_scheduler #(.ZONES(4), .WATER_TICKS(1), .SETTLE_TICKS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .stop(stop),
        .valve(valve_b), .zone(zone_b), .count(count_b), .busy(busy_b), .done(done_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: for each instance, which phase of a zone's turn we are in
    // (0 waiting, 1 watering, 2 settling), who is being served, who was served
    // last, and how many ticks of the current phase have elapsed.
    int phase   [2] = '{0, 0};
    int served  [2] = '{0, 0};
    int prev    [2] = '{3, 3};
    int elapsed [2] = '{0, 0};
    int pulse   [2] = '{0, 0};
    int wlen    [2] = '{10, 1};
    int slen    [2] = '{3, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int pick;
        pulse[k] = 0;
        if (!rst_n) begin
            phase[k] = 0; served[k] = 0; prev[k] = 3; elapsed[k] = 0;
        end else if (stop) begin
            phase[k] = 0; elapsed[k] = 0;
        end else if (phase[k] == 0) begin
            pick = -1;
            for (int off = 4; off >= 1; off--) begin
                if (req[(prev[k] + off) % 4]) pick = (prev[k] + off) % 4;
            end
            if (pick >= 0) begin
                phase[k] = 1; served[k] = pick; prev[k] = pick; elapsed[k] = 0;
            end
        end else if (phase[k] == 1) begin
            if (!req[served[k]] || (tick && elapsed[k] + 1 == wlen[k])) begin
                phase[k] = 2; elapsed[k] = 0; pulse[k] = 1;
            end else if (tick) begin
                elapsed[k]++;
            end
        end else begin
            if (tick) begin
                if (elapsed[k] + 1 == slen[k]) begin
                    phase[k] = 0; elapsed[k] = 0;
                end else begin
                    elapsed[k]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        int exp_valve;
        for (int k = 0; k < 2; k++) begin
            exp_valve = (phase[k] == 1) ? (1 << served[k]) : 0;
            if (k == 0) begin
                check("a_valve", valve_a, exp_valve);
                check("a_zone",  zone_a,  served[k]);
                check("a_count", count_a, elapsed[k]);
                check("a_busy",  busy_a,  phase[k] != 0);
                check("a_done",  done_a,  pulse[k]);
                check("a_onehot", $countones(valve_a) <= 1, 1);
            end else begin
                check("b_valve", valve_b, exp_valve);
                check("b_zone",  zone_b,  served[k]);
                check("b_count", count_b, elapsed[k]);
                check("b_busy",  busy_b,  phase[k] != 0);
                check("b_done",  done_b,  pulse[k]);
                check("b_onehot", $countones(valve_b) <= 1, 1);
            end
        end
    endtask

    task automatic cyc(input logic r, input logic t, input logic [3:0] q, input logic s);
        @(negedge clk);
        rst_n = r; tick = t; req = q; stop = s;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; req = 4'h0; stop = 1'b0;

        // Reset state.
        cyc(0, 0, 4'h0, 0);
        cyc(0, 1, 4'hF, 0);
        check("rst_valve", valve_a, 0);
        check("rst_zone",  zone_a,  0);
        check("rst_busy",  busy_a,  0);

        // Single zone, full watering then settle.
        cyc(1, 0, 4'b0001, 0);
        check("grant_valve", valve_a, 4'b0001);
        check("grant_busy",  busy_a,  1);
        check("grant_count", count_a, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 1, 4'b0001, 0);
            check("count_step", count_a, i);
        end
        cyc(1, 1, 4'b0001, 0);
        check("close_valve", valve_a, 0);
        check("done_pulse",  done_a,  1);
        check("settle_busy", busy_a,  1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 4'b0001, 0);
        check("settle_end", busy_a, 0);

        // Abort at count 6 with a coincident tick: aborted zone loses its turn.
        cyc(0, 0, 4'h0, 0);
        cyc(1, 0, 4'hF, 0);
        check("all_req_zone", zone_a, 0);
        for (int i = 0; i < 6; i++) cyc(1, 1, 4'hF, 0);
        check("pre_stop_count", count_a, 6);
        cyc(1, 1, 4'hF, 1);
        check("stop_busy",  busy_a,  0);
        check("stop_count", count_a, 0);
        check("stop_done",  done_a,  0);
        check("stop_valve", valve_a, 0);
        cyc(1, 0, 4'hF, 0);
        check("after_stop_zone",  zone_a,  1);
        check("after_stop_valve", valve_a, 4'b0010);

        // Early drop while watering.
        cyc(1, 1, 4'hF, 0);
        cyc(1, 1, 4'hD, 0);
        check("drop_done",  done_a,  1);
        check("drop_valve", valve_a, 0);

        // Randomised traffic: occasional reset and stop, sticky requests.
        for (int n = 0; n < 4000; n++) begin
            logic       r, t, s;
            logic [3:0] q;
            r = ($urandom_range(0, 299) != 0);
            t = (n >= 3000) ? 1'b1 : ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 49) == 0);
            q = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : req;
            cyc(r, t, q, s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
